// File: rtl/dmem_loader_if.sv
// dmem_loader_if: groups the loader's control, byte-stream and DMEM write signals.
// Ports: master drives start/len/abort and the byte stream; slave (the loader)
// drives in_ready, the DMEM write port and the status flags.
interface dmem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   len;
  logic                  abort;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, len, abort, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, len, abort, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/dmem_loader.sv
// dmem_loader: streams a little-endian byte image into DMEM from word 0, holding the core in reset.
// Latency: mem_we fires the cycle after the 4th byte of a word; 5 cycles per word back-to-back.
// Backpressure: in_ready drops during the WRITE cycle and whenever the loader is not receiving.
// Ports: clk, rst (async active-low), bus (dmem_loader_if.slave: control, byte stream, DMEM port, status).
// Optional: define DMEM_LOADER_CHECKSUM_EN to require a trailer byte making the 8-bit byte sum zero.
module dmem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_loader_if.slave bus
);

  // Longest load the memory can hold; larger requests saturate to this.
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_WORD = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef DMEM_LOADER_CHECKSUM_EN
    CHK   = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [1:0]            byte_q;
  logic [DATA_WIDTH-9:0] word_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  hold_q;
  logic                  in_ready_c;
  logic                  mem_we_c;
  logic                  done_c;
  logic                  start_ok;
  logic                  xfer;

  // abort beats start, and also blocks any byte transfer in the same cycle.
  assign start_ok = bus.start && !bus.abort;
  assign xfer     = bus.in_valid && in_ready_c && !bus.abort;

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    done_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = (bus.len == '0) ? DONE : RECV;
      end
      RECV: begin
        in_ready_c = 1'b1;
        if (bus.abort)                             state_d = IDLE;
        else if (bus.in_valid && byte_q == 2'd3)   state_d = WRITE;
      end
      WRITE: begin
        // The write itself is never cancelled; abort only redirects what follows.
        mem_we_c = 1'b1;
        if (bus.abort)                 state_d = IDLE;
`ifdef DMEM_LOADER_CHECKSUM_EN
        else if (rem_q == LAST_WORD)   state_d = CHK;
`else
        else if (rem_q == LAST_WORD)   state_d = DONE;
`endif
        else                           state_d = RECV;
      end
`ifdef DMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready_c = 1'b1;
        if (bus.abort)          state_d = IDLE;
        else if (bus.in_valid)  state_d = DONE;
      end
`endif
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cpu_hold is a flop loaded from the next state so it tracks busy without decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d != IDLE);
    end
  end

`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_next;
  logic       err_q;
  assign sum_next = sum_q + bus.in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q       <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      mem_wdata_q <= '0;
`ifdef DMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && start_ok) begin
        rem_q      <= (bus.len > DEPTH) ? DEPTH : bus.len;
        addr_q     <= '0;
        mem_addr_q <= '0;
        byte_q     <= '0;
`ifdef DMEM_LOADER_CHECKSUM_EN
        sum_q      <= '0;
        err_q      <= 1'b0;
`endif
      end
      if (state_q == RECV && xfer) begin
        byte_q <= byte_q + 2'd1;
`ifdef DMEM_LOADER_CHECKSUM_EN
        sum_q  <= sum_next;
`endif
        // Lower bytes park in word_q; the 4th byte publishes the word and its
        // address together so the DMEM port only moves when a write is due.
        case (byte_q)
          2'd0:    word_q[7:0]   <= bus.in_data;
          2'd1:    word_q[15:8]  <= bus.in_data;
          2'd2:    word_q[23:16] <= bus.in_data;
          default: begin
            mem_wdata_q <= {bus.in_data, word_q};
            mem_addr_q  <= addr_q;
          end
        endcase
      end
      if (state_q == WRITE) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LAST_WORD;
      end
`ifdef DMEM_LOADER_CHECKSUM_EN
      if (state_q == CHK && xfer && sum_next != 8'h00) err_q <= 1'b1;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_c;
`ifdef DMEM_LOADER_CHECKSUM_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: self-checking bench for dmem_loader.
// Table of load lengths with expected write counts, hand sequences for timing,
// abort and reset corners, and random loads checked against a byte-image model.
module tb_dmem_loader;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  dmem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int last_wr_cnt = 0;
  int last_wr_addr = 0;
  logic [7:0] sum;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  // Observe the DMEM port and done away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    bus.len   = (AW+1)'(len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    for (int i = 0; i < gap; i++) tick();
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    sum = sum + b;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_trailer_ok();
    logic [7:0] t;
    t = 8'h00 - sum;
    send_byte(t, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("%s_done_seen", name), 32'(bus.done), 32'd1);
    tick();
  endtask

  // Reference: word i is bytes 4i..4i+3, LSB first, at address i; at most 2^AW words.
  task automatic model_load(input int len, input logic [7:0] bytes[$]);
    int n;
    n = (len > (1 << AW)) ? (1 << AW) : len;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_data_q.push_back({bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]});
    end
  endtask

  task automatic compare_writes(input string name);
    int n;
    check($sformatf("%s_wr_count", name), 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr[%0d]", name, i), 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
      check($sformatf("%s_data[%0d]", name, i), wr_data_q[i], exp_data_q[i]);
    end
    last_wr_cnt  = wr_addr_q.size();
    last_wr_addr = (wr_addr_q.size() > 0) ? int'(wr_addr_q[$]) : -1;
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic run_load(input int len, input int nwords, input int max_gap, input string name);
    logic [7:0] bytes[$];
    logic [7:0] b;
    int d0;
    d0  = done_cnt;
    sum = 8'h00;
    start_load(len);
    for (int i = 0; i < 4*nwords; i++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      send_byte(b, (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
    end
`ifdef DMEM_LOADER_CHECKSUM_EN
    if (nwords > 0) send_trailer_ok();
`endif
    wait_done(name);
    model_load(len, bytes);
    compare_writes(name);
    check($sformatf("%s_done_once", name), 32'(done_cnt - d0), 32'd1);
  endtask

  typedef struct {
    int len;
    int words;
    int last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] two_word[8];
    logic       pat[7];
    logic [7:0] stall_b[4];
    int         k;
    int         d0;

    tbl[0] = '{len: 0,   words: 0,   last: -1};
    tbl[1] = '{len: 1,   words: 1,   last: 0};
    tbl[2] = '{len: 2,   words: 2,   last: 1};
    tbl[3] = '{len: 5,   words: 5,   last: 4};
    tbl[4] = '{len: 256, words: 256, last: 255};
    tbl[5] = '{len: 300, words: 256, last: 255};

    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    sum = 8'h00;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata,     32'd0);
    check("rst_cpu_hold",  32'(bus.cpu_hold), 32'd0);
    check("rst_busy",      32'(bus.busy),     32'd0);
    check("rst_done",      32'(bus.done),     32'd0);
    check("rst_err",       32'(bus.err),      32'd0);
    repeat (20) tick();
    check("idle_no_writes", 32'(wr_addr_q.size()), 32'd0);
    check("idle_no_done",   32'(done_cnt),         32'd0);

    // Two-word load with cpu_hold window.
    two_word = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sum = 8'h00;
    d0  = done_cnt;
    start_load(2);
    check("two_hold_after_start", 32'(bus.cpu_hold), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(two_word[i], 0);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_trailer_ok();
`endif
    k = 0;
    while (!bus.done && k < 20) begin tick(); k++; end
    check("two_done_seen",     32'(bus.done),     32'd1);
    check("two_hold_at_done",  32'(bus.cpu_hold), 32'd1);
    tick();
    check("two_hold_after_done", 32'(bus.cpu_hold), 32'd0);
    check("two_busy_after_done", 32'(bus.busy),     32'd0);
    exp_addr_q.push_back(8'h00); exp_data_q.push_back(32'h12345678);
    exp_addr_q.push_back(8'h01); exp_data_q.push_back(32'hDEADBEEF);
    compare_writes("two");
    check("two_done_once", 32'(done_cnt - d0), 32'd1);

    // Stalled source: valid 1-0-0-1-1-0-1.
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    stall_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    sum = 8'h00;
    start_load(1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = pat[i];
      bus.in_data  = stall_b[k];
      tick();
      if (pat[i]) begin
        sum = sum + stall_b[k];
        k++;
      end
      if (i == 5) check("stall_no_early_we", 32'(bus.mem_we), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("stall_we_next_cycle", 32'(bus.mem_we),   32'd1);
    check("stall_addr",          32'(bus.mem_addr), 32'd0);
    check("stall_wdata",         bus.mem_wdata,     32'h04030201);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_trailer_ok();
`endif
    wait_done("stall");
    exp_addr_q.push_back(8'h00); exp_data_q.push_back(32'h04030201);
    compare_writes("stall");

    // len=0: done the very next cycle, no writes.
    d0 = done_cnt;
    start_load(0);
    check("len0_done_next", 32'(bus.done), 32'd1);
    tick();
    check("len0_idle", 32'(bus.busy), 32'd0);
    compare_writes("len0");
    check("len0_done_once", 32'(done_cnt - d0), 32'd1);

    // Table of lengths including saturation.
    foreach (tbl[i]) begin
      run_load(tbl[i].len, tbl[i].words, 0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_count", i), 32'(last_wr_cnt),  32'(tbl[i].words));
      check($sformatf("tbl%0d_last", i),  32'(last_wr_addr), 32'(tbl[i].last));
    end

    // start together with abort is ignored.
    bus.abort = 1'b1;
    start_load(4);
    bus.abort = 1'b0;
    check("start_abort_idle", 32'(bus.busy), 32'd0);

    // Abort after 2 bytes of word 1 of a 3-word load.
    d0  = done_cnt;
    sum = 8'h00;
    start_load(3);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy",     32'(bus.busy),     32'd0);
    check("abort_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    repeat (6) tick();
    exp_addr_q.push_back(8'h00); exp_data_q.push_back(32'h44332211);
    compare_writes("abort");
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    sum = 8'h00;
    start_load(1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_trailer_ok();
`endif
    wait_done("reload");
    exp_addr_q.push_back(8'h00); exp_data_q.push_back(32'hDDCCBBAA);
    compare_writes("reload");

    // Reset during the WRITE cycle kills mem_we at once.
    sum = 8'h00;
    start_load(2);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    check("rstmid_we_before", 32'(bus.mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid_we_now", 32'(bus.mem_we),   32'd0);
    check("rstmid_busy",   32'(bus.busy),     32'd0);
    check("rstmid_hold",   32'(bus.cpu_hold), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    compare_writes("rstmid");

`ifdef DMEM_LOADER_CHECKSUM_EN
    // Trailer F6 balances 01..04; F5 does not.
    d0  = done_cnt;
    sum = 8'h00;
    start_load(1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF6, 0);
    k = 0;
    while (!bus.done && k < 20) begin tick(); k++; end
    check("chk_good_err", 32'(bus.err), 32'd0);
    tick();
    start_load(1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF5, 0);
    k = 0;
    while (!bus.done && k < 20) begin tick(); k++; end
    check("chk_bad_err", 32'(bus.err), 32'd1);
    repeat (3) tick();
    check("chk_err_holds", 32'(bus.err), 32'd1);
    check("chk_done_both", 32'(done_cnt - d0), 32'd2);
    wr_addr_q.delete(); wr_data_q.delete();
`endif

    // Random loads with random source gaps.
    for (int r = 0; r < 8; r++) begin
      k = int'($urandom_range(6, 1));
      run_load(k, k, 3, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
